// File: rtl/std_feed_pkg.sv
// Shared types and constants for the std-deviation feed sequencer.
// Holds the FSM state enum, datapath widths and the minimum spacing
// constants the top-level parameters are checked against.
package std_feed_pkg;

  // Sample, result and count widths on the std calculator interface
  localparam int EEG_W = 18;
  localparam int STD_W = 19;
  localparam int CNT_W = 8;

  // Largest window the 8-bit count output can describe
  localparam int MAX_WINDOW = 255;

  // The calculator's multiplier needs 3 cycles plus an edge detect between
  // start pulses, and the accumulator needs one more cycle to settle before
  // the accumulation-complete pulse.
  localparam int MIN_SAMPLE_GAP = 5;
  localparam int MIN_FLUSH_GAP  = 6;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FILL,
    ST_WAIT_MEAN,
    ST_ISSUE,
    ST_GAP,
    ST_FLUSH,
    ST_WAIT_SQRT,
    ST_OUT
  } std_feed_state_t;

  // True while a window is being replayed into the calculator; mean pulses
  // arriving in these states belong to the next window and are ignored.
  function automatic logic isReplay(input std_feed_state_t s);
    return (s == ST_ISSUE) || (s == ST_GAP) ||
           (s == ST_FLUSH) || (s == ST_WAIT_SQRT);
  endfunction

endpackage

// File: rtl/std_feed_buf.sv
// Window sample buffer: simple dual-port memory with one write port and a
// registered read port. The read address is sampled every cycle so the
// controller can prefetch the next sample one cycle ahead of its start pulse.
module std_feed_buf
  import std_feed_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [EEG_W-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [EEG_W-1:0] rd_data_o
);

  logic [EEG_W-1:0] mem_q [DEPTH];
  logic [EEG_W-1:0] rdData_q;

  // Write port: store an accepted sample at the write address
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port: data appears the cycle after the address
  always_ff @(posedge clk) begin
    rdData_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/std_feed_ctrl.sv
// Window sequencer for the standard-deviation calculator. Buffers one
// window of EEG samples, latches the window mean, replays each sample as a
// spaced start pulse, closes the accumulation and captures the result on
// the calculator's square-root completion edge.
module std_feed_ctrl
  import std_feed_pkg::*;
#(
  parameter int MAX_SAMPLES = 128,
  parameter int SAMPLE_GAP  = 6,
  parameter int FLUSH_GAP   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [EEG_W-1:0] in_eeg,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             mean_valid,
  input  logic [EEG_W-1:0] mean_in,
  output logic             start,
  output logic [EEG_W-1:0] eeg,
  output logic [EEG_W-1:0] mean,
  output logic [CNT_W-1:0] count,
  output logic             complete_acc,
  input  logic             complete_sqrt,
  input  logic [STD_W-1:0] std_dev,
  output logic             std_valid,
  output logic [STD_W-1:0] std_out,
  output logic             err
);

  // Pointers carry one extra bit so a full window (wr_ptr == MAX_SAMPLES)
  // is distinguishable from an empty one.
  localparam int AW    = $clog2(MAX_SAMPLES);
  localparam int PTR_W = AW + 1;

  // The gap counter measures cycles since the last start pulse and serves
  // both the inter-sample spacing and the flush delay.
  localparam int GAP_MAX = (SAMPLE_GAP > FLUSH_GAP) ? SAMPLE_GAP : FLUSH_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX + 2);

  // After the final start pulse, GAP hands over to FLUSH early enough that
  // FLUSH can still count up to FLUSH_GAP even when FLUSH_GAP < SAMPLE_GAP.
  localparam int GAP_TO_FLUSH =
    ((SAMPLE_GAP < FLUSH_GAP) ? SAMPLE_GAP : FLUSH_GAP) - 1;

  // Reject parameter sets the calculator cannot keep up with
  if (SAMPLE_GAP < MIN_SAMPLE_GAP) begin : gBadSampleGap
    $error("std_feed_ctrl: SAMPLE_GAP below the calculator minimum");
  end
  if (FLUSH_GAP < MIN_FLUSH_GAP) begin : gBadFlushGap
    $error("std_feed_ctrl: FLUSH_GAP below the calculator minimum");
  end
  if ((MAX_SAMPLES < 2) || (MAX_SAMPLES > MAX_WINDOW)) begin : gBadDepth
    $error("std_feed_ctrl: MAX_SAMPLES outside 2..255");
  end

  std_feed_state_t  state_q, state_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic             meanLatched_q, meanLatched_d;
  logic [EEG_W-1:0] mean_q, mean_d;
  logic [STD_W-1:0] stdOut_q, stdOut_d;
  logic             err_q, err_d;
  logic             sqrtDly_q;

  logic             accept;
  logic             atCapacity;
  logic             windowEnd;
  logic             shortWin;
  logic             samplesLeft;
  logic             sqrtRise;
  logic [EEG_W-1:0] rdData;

  assign accept      = in_valid && (state_q == ST_FILL);
  assign atCapacity  = (wrPtr_q == PTR_W'(MAX_SAMPLES - 1));
  assign windowEnd   = accept && (in_last || atCapacity);
  assign shortWin    = windowEnd && (wrPtr_q == '0);
  assign samplesLeft = (rdPtr_q != wrPtr_q);
  assign sqrtRise    = complete_sqrt && !sqrtDly_q;

  std_feed_buf #(
    .DEPTH (MAX_SAMPLES),
    .AW    (AW)
  ) uBuf (
    .clk       (clk),
    .wr_en_i   (accept),
    .wr_addr_i (wrPtr_q[AW-1:0]),
    .wr_data_i (in_eeg),
    .rd_addr_i (rdPtr_q[AW-1:0]),
    .rd_data_o (rdData)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fill, wait for the mean, replay with spacing, flush,
  // wait for the result edge, then report and start over.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: begin
        if (windowEnd && !shortWin) begin
          state_d = ST_WAIT_MEAN;
        end
      end
      ST_WAIT_MEAN: begin
        if (meanLatched_q) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (samplesLeft) begin
          if (gapCnt_q == GAP_W'(SAMPLE_GAP - 1)) begin
            state_d = ST_ISSUE;
          end
        end else if (gapCnt_q == GAP_W'(GAP_TO_FLUSH)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (gapCnt_q == GAP_W'(FLUSH_GAP)) begin
          state_d = ST_WAIT_SQRT;
        end
      end
      ST_WAIT_SQRT: begin
        if (sqrtRise) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        state_d = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Outputs decoded from the current state; the replayed sample is only
  // driven while its start pulse is high.
  always_comb begin
    in_ready     = (state_q == ST_FILL) && !reset;
    start        = (state_q == ST_ISSUE);
    eeg          = (state_q == ST_ISSUE) ? rdData : '0;
    complete_acc = (state_q == ST_FLUSH) && (gapCnt_q == GAP_W'(FLUSH_GAP));
    std_valid    = (state_q == ST_OUT);
  end

  // Datapath next-state: pointers, count, gap timer, mean latch, result
  // capture and the sticky error flag.
  always_comb begin
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    count_d       = count_q;
    gapCnt_d      = gapCnt_q;
    meanLatched_d = meanLatched_q;
    mean_d        = mean_q;
    stdOut_d      = stdOut_q;
    err_d         = err_q;

    if (accept) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(1);
      if (wrPtr_q == '0) begin
        err_d = 1'b0;
      end
    end

    // A window hitting capacity without in_last is truncated and flagged
    if (windowEnd && atCapacity && !in_last) begin
      err_d = 1'b1;
    end

    // A one-sample window would divide by zero downstream; drop it
    if (shortWin) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      err_d   = 1'b1;
    end

    if (state_q == ST_ISSUE) begin
      rdPtr_d  = rdPtr_q + PTR_W'(1);
      gapCnt_d = GAP_W'(1);
    end

    if ((state_q == ST_GAP) || (state_q == ST_FLUSH)) begin
      gapCnt_d = gapCnt_q + GAP_W'(1);
    end

    if ((state_q == ST_WAIT_SQRT) && sqrtRise) begin
      stdOut_d = std_dev;
    end

    if (state_q == ST_OUT) begin
      meanLatched_d = 1'b0;
      wrPtr_d       = '0;
      rdPtr_d       = '0;
      count_d       = '0;
    end

    // A mean arriving outside replay belongs to the window being filled;
    // it is applied after the OUT clear so a pulse in OUT is not lost.
    if (mean_valid && !isReplay(state_q)) begin
      meanLatched_d = 1'b1;
      mean_d        = mean_in;
    end
  end

  // Datapath registers; reset aborts any window in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      gapCnt_q      <= '0;
      meanLatched_q <= 1'b0;
      mean_q        <= '0;
      stdOut_q      <= '0;
      err_q         <= 1'b0;
      sqrtDly_q     <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      gapCnt_q      <= gapCnt_d;
      meanLatched_q <= meanLatched_d;
      mean_q        <= mean_d;
      stdOut_q      <= stdOut_d;
      err_q         <= err_d;
      sqrtDly_q     <= complete_sqrt;
    end
  end

  assign mean    = mean_q;
  assign count   = count_q;
  assign std_out = stdOut_q;
  assign err     = err_q;

endmodule

// File: tb/tb_std_feed_ctrl.sv
// Testbench for std_feed_ctrl: drives windows of random samples, models
// the expected start/complete/result timing from the window rules and
// compares against a negedge monitor of the DUT outputs.
module tb_std_feed_ctrl;
  import std_feed_pkg::*;

  localparam int MAX_SAMPLES = 128;
  localparam int SAMPLE_GAP  = 6;
  localparam int FLUSH_GAP   = 6;

  logic             clk;
  logic             reset;
  logic             inValid;
  logic [EEG_W-1:0] inEeg;
  logic             inLast;
  logic             inReady;
  logic             meanValid;
  logic [EEG_W-1:0] meanIn;
  logic             start;
  logic [EEG_W-1:0] eeg;
  logic [EEG_W-1:0] mean;
  logic [CNT_W-1:0] count;
  logic             completeAcc;
  logic             completeSqrt;
  logic [STD_W-1:0] stdDev;
  logic             stdValid;
  logic [STD_W-1:0] stdOut;
  logic             err;

  std_feed_ctrl #(
    .MAX_SAMPLES (MAX_SAMPLES),
    .SAMPLE_GAP  (SAMPLE_GAP),
    .FLUSH_GAP   (FLUSH_GAP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (inValid),
    .in_eeg        (inEeg),
    .in_last       (inLast),
    .in_ready      (inReady),
    .mean_valid    (meanValid),
    .mean_in       (meanIn),
    .start         (start),
    .eeg           (eeg),
    .mean          (mean),
    .count         (count),
    .complete_acc  (completeAcc),
    .complete_sqrt (completeSqrt),
    .std_dev       (stdDev),
    .std_valid     (stdValid),
    .std_out       (stdOut),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Window under test and the cycles at which its last sample and its
  // effective mean pulse were presented
  logic [EEG_W-1:0] winSamples[$];
  int lastCyc;
  int meanCyc;

  // Monitor records
  int               startCyc[$];
  logic [EEG_W-1:0] startEeg[$];
  logic [EEG_W-1:0] startMean[$];
  logic [CNT_W-1:0] startCnt[$];
  int               accCyc[$];
  int               validCyc[$];
  logic [STD_W-1:0] validStd[$];
  int               overlapCnt = 0;

  // Capture every output event away from the active edge
  always @(negedge clk) begin
    if (start === 1'b1) begin
      startCyc.push_back(cycleCnt);
      startEeg.push_back(eeg);
      startMean.push_back(mean);
      startCnt.push_back(count);
    end
    if (completeAcc === 1'b1) accCyc.push_back(cycleCnt);
    if (stdValid === 1'b1) begin
      validCyc.push_back(cycleCnt);
      validStd.push_back(stdOut);
    end
    if ((start === 1'b1) && (completeAcc === 1'b1)) overlapCnt++;
  end

  // Global guard so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearMonitor();
    startCyc.delete();
    startEeg.delete();
    startMean.delete();
    startCnt.delete();
    accCyc.delete();
    validCyc.delete();
    validStd.delete();
  endtask

  // Drive winSamples; meanMode: -1 none, 0 one cycle after last,
  // 1 with first sample, 2 two pulses (m1 then m2), 3 with last sample
  task automatic applyStimulus(input bit withLast, input int meanMode,
                               input logic [EEG_W-1:0] m1,
                               input logic [EEG_W-1:0] m2);
    int n;
    n = winSamples.size();
    clearMonitor();
    meanCyc = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      inValid   = 1'b1;
      inEeg     = winSamples[i];
      inLast    = withLast && (i == n - 1);
      meanValid = 1'b0;
      if ((meanMode == 1 || meanMode == 2) && i == 0) begin
        meanValid = 1'b1; meanIn = m1; meanCyc = cycleCnt;
      end
      if (meanMode == 2 && i == 1) begin
        meanValid = 1'b1; meanIn = m2; meanCyc = cycleCnt;
      end
      if (meanMode == 3 && i == n - 1) begin
        meanValid = 1'b1; meanIn = m1; meanCyc = cycleCnt;
      end
      if (i == MAX_SAMPLES - 1 || (i == n - 1 && i < MAX_SAMPLES)) lastCyc = cycleCnt;
    end
    @(posedge clk); #1;
    inValid   = 1'b0;
    inLast    = 1'b0;
    meanValid = 1'b0;
    if (meanMode == 0) begin
      meanValid = 1'b1; meanIn = m1; meanCyc = cycleCnt;
      @(posedge clk); #1;
      meanValid = 1'b0;
    end
  endtask

  // Expected replay: start k at max(last, mean)+2+k*gap with sample k,
  // complete_acc FLUSH_GAP after the last start, result one cycle after the
  // completion edge.
  task automatic runReplay(input logic [EEG_W-1:0] expMean, input logic expErr,
                           input logic [STD_W-1:0] stdVal, input int holdCycles);
    int nEff, firstStart, guard, raiseCyc;
    nEff = (winSamples.size() > MAX_SAMPLES) ? MAX_SAMPLES : winSamples.size();
    firstStart = ((lastCyc > meanCyc) ? lastCyc : meanCyc) + 2;
    guard = 0;
    while (accCyc.size() == 0 && guard < nEff * SAMPLE_GAP + 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("acc_seen", accCyc.size(), 1);
    if (accCyc.size() == 0) return;
    checkOutput("acc_cycle", accCyc[0], firstStart + (nEff - 1) * SAMPLE_GAP + FLUSH_GAP);
    checkOutput("start_count", startCyc.size(), nEff);
    for (int k = 0; k < nEff && k < startCyc.size(); k++) begin
      checkOutput($sformatf("start%0d_cycle", k), startCyc[k], firstStart + k * SAMPLE_GAP);
      checkOutput($sformatf("start%0d_eeg", k), startEeg[k], winSamples[k]);
      checkOutput($sformatf("start%0d_mean", k), startMean[k], expMean);
      checkOutput($sformatf("start%0d_count", k), startCnt[k], nEff);
    end
    checkOutput("err_replay", err, expErr);

    // Calculator model: completion level held high, dropped 3 cycles, raised
    repeat (holdCycles) @(posedge clk);
    #1;
    completeSqrt = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    completeSqrt = 1'b1;
    stdDev       = stdVal;
    raiseCyc     = cycleCnt;
    guard = 0;
    while (validCyc.size() == 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("valid_seen", validCyc.size(), 1);
    if (validCyc.size() == 0) return;
    checkOutput("valid_cycle", validCyc[0], raiseCyc + 1);
    checkOutput("std_at_valid", validStd[0], stdVal);
    @(negedge clk);
    checkOutput("ready_after_out", inReady, 1);
    checkOutput("count_cleared", count, 0);
    repeat (3) @(negedge clk);
    checkOutput("valid_once", validCyc.size(), 1);
    checkOutput("std_held", stdOut, stdVal);
  endtask

  initial begin
    int guard;
    int n;
    int mode;
    logic [EEG_W-1:0] m1, m2;
    logic [STD_W-1:0] sv;

    reset = 1'b1; inValid = 1'b0; inEeg = '0; inLast = 1'b0;
    meanValid = 1'b0; meanIn = '0; completeSqrt = 1'b1; stdDev = '0;
    lastCyc = 0; meanCyc = -1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", inReady, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_complete_acc", completeAcc, 0);
    checkOutput("rst_std_valid", stdValid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_eeg", eeg, 0);
    checkOutput("rst_mean", mean, 0);
    checkOutput("rst_std_out", stdOut, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", inReady, 1);

    // Basic window with result capture
    winSamples = '{18'h01000, 18'h02000, 18'h03000, 18'h04000};
    applyStimulus(1'b1, 0, 18'h02800, 18'h0);
    runReplay(18'h02800, 1'b0, 19'h0A100, 0);

    // Mean before last sample: no stall; level-high completion on entry
    winSamples.delete();
    for (int i = 0; i < 5; i++) winSamples.push_back(EEG_W'($urandom()));
    m1 = EEG_W'($urandom());
    applyStimulus(1'b1, 1, m1, 18'h0);
    guard = 0;
    while (startCyc.size() == 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("first_start_no_stall", (startCyc.size() > 0) ? startCyc[0] : -1, lastCyc + 2);
    runReplay(m1, 1'b0, STD_W'($urandom()), 4);

    // Second mean pulse overwrites the first
    winSamples.delete();
    for (int i = 0; i < 6; i++) winSamples.push_back(EEG_W'($urandom()));
    m1 = EEG_W'($urandom());
    m2 = EEG_W'($urandom());
    applyStimulus(1'b1, 2, m1, m2);
    runReplay(m2, 1'b0, STD_W'($urandom()), 0);

    // Mean together with the last sample
    winSamples.delete();
    for (int i = 0; i < 3; i++) winSamples.push_back(EEG_W'($urandom()));
    m1 = EEG_W'($urandom());
    applyStimulus(1'b1, 3, m1, 18'h0);
    runReplay(m1, 1'b0, STD_W'($urandom()), 1);

    // Random windows with random mean arrival
    for (int w = 0; w < 3; w++) begin
      n    = int'($urandom_range(3, 12));
      mode = int'($urandom_range(0, 3));
      winSamples.delete();
      for (int i = 0; i < n; i++) winSamples.push_back(EEG_W'($urandom()));
      m1 = EEG_W'($urandom());
      m2 = EEG_W'($urandom());
      sv = STD_W'($urandom());
      applyStimulus(1'b1, mode, m1, m2);
      runReplay((mode == 2) ? m2 : m1, 1'b0, sv, int'($urandom_range(0, 3)));
    end

    // One-sample window is discarded with err
    winSamples = '{18'h00123};
    applyStimulus(1'b1, -1, 18'h0, 18'h0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("short_no_start", startCyc.size(), 0);
    checkOutput("short_err", err, 1);
    checkOutput("short_in_fill", inReady, 1);
    checkOutput("short_count", count, 0);

    // Next normal window clears err on its first sample
    winSamples.delete();
    for (int i = 0; i < 4; i++) winSamples.push_back(EEG_W'($urandom()));
    m1 = EEG_W'($urandom());
    applyStimulus(1'b1, 1, m1, 18'h0);
    runReplay(m1, 1'b0, STD_W'($urandom()), 0);

    // 129 samples without in_last: truncated to 128 with err
    winSamples.delete();
    for (int i = 0; i < MAX_SAMPLES + 1; i++) winSamples.push_back(EEG_W'($urandom()));
    m1 = EEG_W'($urandom());
    applyStimulus(1'b0, 0, m1, 18'h0);
    runReplay(m1, 1'b1, STD_W'($urandom()), 0);

    // Reset after the second start pulse
    winSamples.delete();
    for (int i = 0; i < 5; i++) winSamples.push_back(EEG_W'($urandom()));
    m1 = EEG_W'($urandom());
    applyStimulus(1'b1, 0, m1, 18'h0);
    guard = 0;
    while (startCyc.size() < 2 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("two_starts_before_rst", startCyc.size(), 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_in_ready", inReady, 0);
    checkOutput("midrst_start", start, 0);
    checkOutput("midrst_complete_acc", completeAcc, 0);
    checkOutput("midrst_std_valid", stdValid, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_eeg", eeg, 0);
    checkOutput("midrst_mean", mean, 0);
    checkOutput("midrst_std_out", stdOut, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    clearMonitor();
    @(negedge clk);
    checkOutput("midrst_ready_after", inReady, 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrst_no_replay", startCyc.size() + accCyc.size(), 0);

    // Fresh 3-sample window completes normally after the abort
    winSamples.delete();
    for (int i = 0; i < 3; i++) winSamples.push_back(EEG_W'($urandom()));
    m1 = EEG_W'($urandom());
    applyStimulus(1'b1, 0, m1, 18'h0);
    runReplay(m1, 1'b0, STD_W'($urandom()), 0);

    checkOutput("start_acc_overlap", overlapCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/std_feed_ctrl.md
# std_feed_ctrl

Window sequencer that drives the standard-deviation calculator's input side and collects its result. It buffers one window of EEG samples and latches the window mean from the mean block. It then replays every sample to the std calculator as spaced single-cycle start pulses, issues the accumulation-complete pulse, and captures the standard deviation on the calculator's square-root completion. It sits between the EEG sample stream / mean block and the std calculator in the feature-extraction path.

## Interface
- MAX_SAMPLES, 128, buffer depth; windows are capped at this length (≤255).
- SAMPLE_GAP, 6, cycles between consecutive start pulses (min 5, multiplier num_cyc 3 + edge detect).
- FLUSH_GAP, 6, cycles from last start pulse to complete_acc (min 6).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EEG sample valid.
- in_eeg  in  18  EEG sample, Q1.5.12.
- in_last  in  1  qualifies the last sample of the window with in_valid.
- in_ready  out  1  buffer accepting samples (FILL state only).
- mean_valid  in  1  window mean valid, one-cycle pulse.
- mean_in  in  18  window mean, Q1.5.12.
- start  out  1  per-sample strobe to the std calculator.
- eeg  out  18  replayed sample; valid in the cycle start is high.
- mean  out  18  latched mean; held for the whole replay.
- count  out  8  window sample count; held from replay to capture.
- complete_acc  out  1  one-cycle pulse ending accumulation.
- complete_sqrt  in  1  std calculator completion, level.
- std_dev  in  19  std calculator result, Q1.6.12.
- std_valid  out  1  one-cycle result pulse.
- std_out  out  19  captured std_dev; held until the next capture.
- err  out  1  sticky error flag; cleared when the next window's first sample is accepted.

## Operation
- FSM states: FILL, WAIT_MEAN, ISSUE, GAP, FLUSH, WAIT_SQRT, OUT.
- **FILL**
  - in_ready=1.
  - Each in_valid writes in_eeg at wr_ptr and increments wr_ptr and the count.
  - Exit on in_last, or when the MAX_SAMPLES-th sample is accepted without in_last. The second case is an implicit last and sets err.
  - Exit goes to WAIT_MEAN.
- **Short window**: a window ending with count<2 is discarded. Set err, reset pointers, stay in FILL. This avoids count-1=0 in the divider.
- **Mean latch**: mean_valid is latched in any state except replay (ISSUE/GAP/FLUSH/WAIT_SQRT). A later pulse overwrites the earlier one. Pulses during replay are ignored.
- **WAIT_MEAN**: in_ready=0. Go to ISSUE once mean_latched is set; this may already be true on entry.
- **ISSUE**
  - start=1 for one cycle, eeg=buffer[rd_ptr]. The read is prefetched one cycle earlier from the registered-read buffer.
  - rd_ptr++. Go to GAP.
- **GAP**: wait SAMPLE_GAP-1 cycles. Then go to ISSUE if samples remain, else to FLUSH.
- **FLUSH**: wait FLUSH_GAP cycles after the last start, then pulse complete_acc and go to WAIT_SQRT.
- **WAIT_SQRT**
  - Register complete_sqrt every cycle.
  - Capture std_dev into std_out on the first rising edge (complete_sqrt & !complete_sqrt_d) seen in this state. A level-high complete_sqrt on entry is not a capture.
  - Go to OUT.
- **OUT**
  - std_valid=1 for one cycle.
  - Clear mean_latched, wr_ptr, rd_ptr and count. Return to FILL.
- start and complete_acc are never high in the same cycle. Samples presented while in_ready=0 are dropped; the upstream honours in_ready.

## Timing
- **Reset values**: state=FILL, in_ready=0 during reset and 1 the cycle after. start, complete_acc, std_valid, err, count, eeg, mean, std_out all 0.
- **Reset mid-operation**: abort immediately. Buffer contents are don't-care, pointers and flags are cleared.
- **Last sample accepted at cycle T, mean already latched**: WAIT_MEAN at T+1, first start at T+2.
- **Start pulse k** (k=0..count-1): at T+2+k·SAMPLE_GAP.
- **complete_acc**: at T+2+(count-1)·SAMPLE_GAP+FLUSH_GAP.
- **std_valid**: one cycle after the captured rising edge of complete_sqrt.
- **Simultaneous in_valid+in_last and mean_valid**: both take effect. Go to WAIT_MEAN, then ISSUE the next cycle.
- **Pointer widths**: $clog2(MAX_SAMPLES)+1. count = number of samples accepted, max MAX_SAMPLES.

## Structure
- Package std_feed_pkg holds:
  - state enum std_feed_state_t
  - EEG_W=18, STD_W=19, CNT_W=8
  - minimum-gap constants checked by parameter assertions
- Sub-module std_feed_buf: MAX_SAMPLES×18 simple dual-port buffer, one write port, registered read port.
- FSM, counters and capture logic live in std_feed_ctrl.

## Test plan
- **Basic window**
  - Stimulus: 4 samples 0x01000, 0x02000, 0x03000, 0x04000 (last on 4th); mean 0x02800 one cycle later.
  - Response: 4 start pulses exactly SAMPLE_GAP apart with matching eeg; count=4; mean=0x02800; complete_acc at FLUSH_GAP after the 4th start.
- **Result capture**
  - Stimulus: model holds complete_sqrt high, drops it for 3 cycles after complete_acc, raises it with std_dev=0x0A100.
  - Response: std_out=0x0A100, std_valid pulses once, in_ready=1 the following cycle.
- **Mean arrival order**
  - Stimulus: mean pulsed during FILL before in_last.
  - Response: no WAIT_MEAN stall; first start 2 cycles after the last sample.
- **Mean overwrite**
  - Stimulus: a second mean pulse before in_last.
  - Response: the second value is used.
- **Window limits**
  - Stimulus: 1-sample window.
  - Response: no start pulses, err=1, back in FILL.
  - Stimulus: 129 samples with no in_last.
  - Response: replay of 128, err=1, count=128.
- **Reset mid-replay**
  - Stimulus: reset asserted after 2nd start pulse.
  - Response: all outputs 0. A new 3-sample window then completes normally and err clears on its first sample.
